// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC register and IF/ID pipeline register with stall, flush and redirect.
// Optional fetch/bubble counters enabled by FETCH_PERF_CNT_EN.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 256,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_inst_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_inst_o,
  output logic        if_id_valid_o,
  output logic        fetch_oob_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count_o,
  output logic [31:0] bubble_count_o
`endif
);
  logic [31:0] pc_q, pc_d, pc4;
  logic [31:0] id_pc_q, id_pc_d, id_pc4_q, id_pc4_d, id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        load, bubble;
  assign pc4         = pc_q + 32'd4;
  assign imem_addr_o = pc_q;
  assign fetch_oob_o = pc_q > 32'(IMEM_BYTES - 4);
  // A redirect overrides a stall; otherwise a stall freezes both registers.
  assign load   = branch_taken_i | ~stall_i;
  assign bubble = branch_taken_i | flush_i | fetch_oob_o;
  always_comb begin
    pc_d       = branch_taken_i ? {branch_target_i[31:2], 2'b00} : stall_i ? pc_q : pc4;
    id_pc_d    = !load ? id_pc_q : bubble ? 32'd0 : pc_q;
    id_pc4_d   = !load ? id_pc4_q : bubble ? 32'd0 : pc4;
    id_inst_d  = !load ? id_inst_q : bubble ? NOP_INST : imem_inst_i;
    id_valid_d = !load ? id_valid_q : ~bubble;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end
  assign if_id_pc_o    = id_pc_q;
  assign if_id_pc4_o   = id_pc4_q;
  assign if_id_inst_o  = id_inst_q;
  assign if_id_valid_o = id_valid_q;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_q + 32'(load & ~bubble);
      bubble_cnt_q <= bubble_cnt_q + 32'(load & bubble);
    end
  end
  assign fetch_count_o  = fetch_cnt_q;
  assign bubble_count_o = bubble_cnt_q;
`endif
endmodule
